// File: rtl/conv_acc_if.sv
// conv_acc_if: term input, configuration, result output and status signals of conv_acc.
interface conv_acc_if #(
  parameter int OPC_LEN = 25,
  parameter int OUT_LEN = 16
);
  logic               i_valid;
  logic [OPC_LEN-1:0] i_pconv;
  logic               o_in_ready;
  logic [7:0]         i_cfg_terms;
  logic [4:0]         i_cfg_shift;
  logic               i_cfg_relu;
  logic               o_valid;
  logic [OUT_LEN-1:0] o_data;
  logic               i_ready;
  logic               o_busy;
  logic               o_drop;
  modport master (
    output i_valid, i_pconv, i_cfg_terms, i_cfg_shift, i_cfg_relu, i_ready,
    input  o_in_ready, o_valid, o_data, o_busy, o_drop
  );
  modport slave (
    input  i_valid, i_pconv, i_cfg_terms, i_cfg_shift, i_cfg_relu, i_ready,
    output o_in_ready, o_valid, o_data, o_busy, o_drop
  );
endinterface

// File: rtl/conv_acc.sv
// conv_acc: accumulates N signed partial-convolution terms, rounds, shifts, applies ReLU,
// saturates and queues each result in a 2-deep in-order output FIFO.
module conv_acc #(
  parameter int OPC_LEN = 25,
  parameter int ACC_LEN = 32,
  parameter int OUT_LEN = 16
) (
  input logic       clk,
  input logic       rst,
  conv_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, RND} state_t;
  localparam logic signed [ACC_LEN:0] SAT_MAX = {{(ACC_LEN-OUT_LEN+2){1'b0}}, {(OUT_LEN-1){1'b1}}};
  localparam logic signed [ACC_LEN:0] SAT_MIN = ~SAT_MAX;
  state_t                    r_state, w_next;
  logic [ACC_LEN-1:0]        r_acc;
  logic [7:0]                r_cnt, r_terms;
  logic [4:0]                r_shift;
  logic                      r_relu;
  logic [OUT_LEN-1:0]        r_mem [2];
  logic                      r_wr, r_rd, r_drop;
  logic [1:0]                r_count;
  logic                      w_in_ready, w_take, w_push, w_pop;
  logic [7:0]                w_terms_in, w_cnt_inc;
  logic [ACC_LEN-1:0]        w_ext;
  logic signed [ACC_LEN:0]   w_rnd, w_sum, w_shr, w_relu;
  logic [OUT_LEN-1:0]        w_res;
  assign w_terms_in = bus.i_cfg_terms == 8'd0 ? 8'd1 : bus.i_cfg_terms;
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_take     = bus.i_valid && w_in_ready;
  assign w_push     = r_state == RND;
  assign w_pop      = r_count != 2'd0 && bus.i_ready;
  assign w_ext      = {{(ACC_LEN-OPC_LEN){bus.i_pconv[OPC_LEN-1]}}, bus.i_pconv};
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next         = r_state;
    w_in_ready     = r_state != RND && r_count != 2'd2;
    bus.o_in_ready = w_in_ready;
    bus.o_busy     = r_state != IDLE;
    if (r_state == IDLE && w_take) w_next = w_terms_in <= 8'd1 ? RND : ACC;
    else if (r_state == ACC && w_take && w_cnt_inc == r_terms) w_next = RND;
    else if (r_state == RND) w_next = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_terms <= 8'd1;
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else if (w_take && r_state == IDLE) begin
      r_acc   <= w_ext;
      r_cnt   <= 8'd1;
      r_terms <= w_terms_in;
      r_shift <= bus.i_cfg_shift;
      r_relu  <= bus.i_cfg_relu;
    end else if (w_take && r_state == ACC) begin
      r_acc <= r_acc + w_ext;
      r_cnt <= w_cnt_inc;
    end
  // one extra bit keeps the rounding add exact before the shift
  assign w_rnd  = r_shift == 5'd0 ? '0 : (ACC_LEN+1)'(1) << (r_shift - 5'd1);
  assign w_sum  = $signed({r_acc[ACC_LEN-1], r_acc}) + w_rnd;
  assign w_shr  = w_sum >>> r_shift;
  assign w_relu = (r_relu && w_shr[ACC_LEN]) ? '0 : w_shr;
  assign w_res  = w_relu > SAT_MAX ? SAT_MAX[OUT_LEN-1:0] :
                  w_relu < SAT_MIN ? SAT_MIN[OUT_LEN-1:0] : w_relu[OUT_LEN-1:0];
  always_ff @(posedge clk)
    if (rst) begin
      r_mem   <= '{default: '0};
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      if (w_push) r_mem[r_wr] <= w_res;
      r_wr    <= r_wr ^ w_push;
      r_rd    <= r_rd ^ w_pop;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_drop  <= r_drop | (bus.i_valid && !w_in_ready);
    end
  assign bus.o_valid = r_count != 2'd0;
  assign bus.o_data  = r_mem[r_rd];
  assign bus.o_drop  = r_drop;
endmodule

// File: tb/tb_conv_acc.sv
// tb_conv_acc: directed table of accumulation groups plus hand sequences for
// backpressure, simultaneous push/pop and mid-group reset.
module tb_conv_acc;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  conv_acc_if #(.OPC_LEN(25), .OUT_LEN(16)) bus ();
  conv_acc #(.OPC_LEN(25), .ACC_LEN(32), .OUT_LEN(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [7:0] terms;
    logic [4:0] shift;
    logic       relu;
    int         n;
    int         t0, t1, t2;
    int         exp;
  } vec_t;
  localparam int NV = 14;
  vec_t v [NV];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drive(input logic vld, input int val);
    bus.i_valid = vld;
    bus.i_pconv = 25'(val);
  endtask
  task automatic cfg(input logic [7:0] t, input logic [4:0] s, input logic r);
    bus.i_cfg_terms = t;
    bus.i_cfg_shift = s;
    bus.i_cfg_relu  = r;
  endtask
  initial begin
    v[0]  = '{8'd3, 5'd0, 1'b0, 3, 100, -50, 7, 57};
    v[1]  = '{8'd2, 5'd4, 1'b0, 2, 24, 0, 0, 2};
    v[2]  = '{8'd2, 5'd4, 1'b0, 2, -24, 0, 0, -1};
    v[3]  = '{8'd1, 5'd0, 1'b1, 1, -5, 0, 0, 0};
    v[4]  = '{8'd1, 5'd0, 1'b1, 1, 9, 0, 0, 9};
    v[5]  = '{8'd3, 5'd0, 1'b0, 3, 16777215, 16777215, 16777215, 32767};
    v[6]  = '{8'd3, 5'd0, 1'b0, 3, -16777216, -16777216, -16777216, -32768};
    v[7]  = '{8'd0, 5'd0, 1'b0, 1, 123, 0, 0, 123};
    v[8]  = '{8'd2, 5'd1, 1'b1, 2, 3, 0, 0, 2};
    v[9]  = '{8'd2, 5'd1, 1'b0, 2, -3, 0, 0, -1};
    v[10] = '{8'd1, 5'd2, 1'b0, 1, -6, 0, 0, -1};
    v[11] = '{8'd1, 5'd2, 1'b0, 1, 6, 0, 0, 2};
    v[12] = '{8'd2, 5'd0, 1'b1, 2, -10, 4, 0, 0};
    v[13] = '{8'd2, 5'd0, 1'b0, 2, -10, 4, 0, -6};
    rst = 1'b1;
    drive(1'b0, 0);
    cfg(8'd1, 5'd0, 1'b0);
    bus.i_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.o_valid}, 0);
    chk("rst_busy", {31'd0, bus.o_busy}, 0);
    chk("rst_in_ready", {31'd0, bus.o_in_ready}, 1);
    chk("rst_data", {16'd0, bus.o_data}, 0);
    chk("rst_drop", {31'd0, bus.o_drop}, 0);
    rst = 1'b0;
    tick();
    // config only honoured on a group's first term; later terms carry junk config
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < v[i].n; j++) begin
        if (j == 0) cfg(v[i].terms, v[i].shift, v[i].relu);
        else cfg(8'd1, 5'd7, !v[i].relu);
        drive(1'b1, j == 0 ? v[i].t0 : j == 1 ? v[i].t1 : v[i].t2);
        tick();
      end
      drive(1'b0, 0);
      chk($sformatf("v%0d_lat_low", i), {31'd0, bus.o_valid}, 0);
      chk($sformatf("v%0d_busy", i), {31'd0, bus.o_busy}, 1);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, bus.o_valid}, 1);
      chk($sformatf("v%0d_data", i), {16'd0, bus.o_data}, {16'd0, v[i].exp[15:0]});
    end
    tick();
    chk("drain_valid", {31'd0, bus.o_valid}, 0);
    // backpressure: two results stored, third term dropped
    bus.i_ready = 1'b0;
    cfg(8'd1, 5'd0, 1'b0);
    drive(1'b1, 11);
    tick();
    drive(1'b0, 0);
    chk("bp_rnd_ready", {31'd0, bus.o_in_ready}, 0);
    tick();
    chk("bp_valid1", {31'd0, bus.o_valid}, 1);
    chk("bp_data1", {16'd0, bus.o_data}, 11);
    drive(1'b1, 22);
    tick();
    drive(1'b0, 0);
    tick();
    chk("bp_full_ready", {31'd0, bus.o_in_ready}, 0);
    drive(1'b1, 33);
    tick();
    drive(1'b0, 0);
    chk("bp_drop", {31'd0, bus.o_drop}, 1);
    chk("bp_busy", {31'd0, bus.o_busy}, 0);
    chk("bp_hold", {16'd0, bus.o_data}, 11);
    bus.i_ready = 1'b1;
    tick();
    chk("bp_valid2", {31'd0, bus.o_valid}, 1);
    chk("bp_data2", {16'd0, bus.o_data}, 22);
    tick();
    chk("bp_empty", {31'd0, bus.o_valid}, 0);
    // push and pop in the same cycle
    bus.i_ready = 1'b0;
    drive(1'b1, 40);
    tick();
    drive(1'b0, 0);
    tick();
    chk("pp_data1", {16'd0, bus.o_data}, 40);
    drive(1'b1, 50);
    tick();
    drive(1'b0, 0);
    bus.i_ready = 1'b1;
    tick();
    chk("pp_valid2", {31'd0, bus.o_valid}, 1);
    chk("pp_data2", {16'd0, bus.o_data}, 50);
    tick();
    chk("pp_empty", {31'd0, bus.o_valid}, 0);
    // reset in the middle of a group
    cfg(8'd3, 5'd0, 1'b0);
    drive(1'b1, 5);
    tick();
    drive(1'b1, 5);
    tick();
    drive(1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", {31'd0, bus.o_busy}, 0);
    chk("mr_valid", {31'd0, bus.o_valid}, 0);
    chk("mr_drop", {31'd0, bus.o_drop}, 0);
    chk("mr_in_ready", {31'd0, bus.o_in_ready}, 1);
    for (int j = 1; j <= 3; j++) begin
      drive(1'b1, j);
      tick();
    end
    drive(1'b0, 0);
    chk("mr_lat_low", {31'd0, bus.o_valid}, 0);
    tick();
    chk("mr_valid_res", {31'd0, bus.o_valid}, 1);
    chk("mr_data", {16'd0, bus.o_data}, 6);
    tick();
    chk("mr_no_stale", {31'd0, bus.o_valid}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_acc.md
CONV_ACC -- requirements
Module: conv_acc

Interface
REQ-001 SHALL have parameter OPC_LEN, default 25, width of one signed partial-convolution input term.
REQ-002 SHALL have parameter ACC_LEN, default 32, width of the signed internal accumulator.
REQ-003 SHALL have parameter OUT_LEN, default 16, width of the signed saturated output.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port i_valid  input  1  i_pconv carries a valid term this cycle.
REQ-007 Port i_pconv  input  OPC_LEN  signed partial-convolution term, from the 3-tap multiply-add stage upstream.
REQ-008 Port o_in_ready  output  1  block accepts a term this cycle.
REQ-009 Port i_cfg_terms  input  8  number of terms per output group; 0 is treated as 1.
REQ-010 Port i_cfg_shift  input  5  arithmetic right-shift amount applied after accumulation.
REQ-011 Port i_cfg_relu  input  1  clamp negative results to 0.
REQ-012 Port o_valid  output  1  o_data holds a valid result.
REQ-013 Port o_data  output  OUT_LEN  signed result.
REQ-014 Port i_ready  input  1  downstream consumes o_data when o_valid and i_ready are both high.
REQ-015 Port o_busy  output  1  a group is in progress (state not IDLE).
REQ-016 Port o_drop  output  1  sticky flag: a term was presented while o_in_ready was low.

Function
REQ-017 FSM SHALL have three states: IDLE, ACC and RND.
REQ-018 A term SHALL be accepted when i_valid && o_in_ready.
REQ-019 o_in_ready SHALL equal (state != RND) && (fifo_count != 2).
REQ-020 IDLE, term accepted: acc <= sign-extended i_pconv; cnt <= 1; i_cfg_* latched; next state RND if latched terms <= 1, else ACC.
REQ-021 ACC, term accepted: acc <= acc + sign-extended i_pconv (modulo 2^ACC_LEN); cnt <= cnt + 1; next state RND when cnt + 1 == latched terms.
REQ-022 ACC, no term accepted: state, acc and cnt SHALL hold; gaps between terms are allowed.
REQ-023 Configuration inputs SHALL be ignored except in the cycle the first term of a group is accepted.
REQ-024 RND (exactly one cycle) computes r = (acc + (shift ? 2^(shift-1) : 0)) >>> shift, arithmetic and sign-preserving.
REQ-025 RND then applies ReLU when latched: r < 0 gives 0.
REQ-026 RND then saturates r to [-2^(OUT_LEN-1), 2^(OUT_LEN-1)-1].
REQ-027 RND pushes the saturated result into the output FIFO and returns to IDLE.
REQ-028 Output FIFO SHALL have depth 2 and be strictly in order; o_valid = (fifo_count != 0); o_data = FIFO head.
REQ-029 Push and pop in the same cycle SHALL leave fifo_count unchanged and return the correct ordering.
REQ-030 RND SHALL always find FIFO space, guaranteed by REQ-019; no overwrite is permitted.
REQ-031 Latency: last term accepted in cycle T gives o_valid high in cycle T+2 when the FIFO was empty and undrained.
REQ-032 o_valid and o_data SHALL remain stable while o_valid && !i_ready.
REQ-033 i_valid && !o_in_ready SHALL discard the term and set o_drop; o_drop is cleared only by reset.
REQ-034 Throughput: with terms = N and no backpressure, one result per N+1 cycles.

Reset
REQ-035 When rst is high at a clock edge: state = IDLE, acc = 0, cnt = 0, fifo_count = 0, o_drop = 0.
REQ-036 Reset values SHALL give o_valid = 0, o_busy = 0, o_in_ready = 1, o_data = 0.
REQ-037 Reset mid-group or mid-output SHALL discard the partial accumulation and all FIFO contents.

Verification
REQ-038 terms=3, shift=0, relu=0; terms 100, -50, 7 on consecutive cycles -> o_data = 57 with o_valid two cycles after the third term.
REQ-039 terms=2, shift=4: terms 24, 0 -> 2; then -24, 0 -> -1 (round-half-up, arithmetic shift).
REQ-040 terms=1, relu=1: term -5 -> 0; term 9 -> 9; o_valid back-to-back each 2 cycles after input.
REQ-041 terms=3, shift=0: three terms of 0x0FFFFFF -> 32767; three terms of 0x1000000 (-16777216) -> -32768.
REQ-042 i_ready=0, terms=1: three terms -> first two stored, o_in_ready low, third discarded, o_drop = 1; raise i_ready -> two results in order, then o_valid = 0.
REQ-043 terms=3: accept 2 terms, assert rst for one cycle, then send 1, 2, 3 -> single result 6, no stale output.
